// File: rtl/vga_mode_sequencer.sv
// Hardware mode-set initiator: on start, replays a fixed per-mode table of register
// writes over the data_m_* master bus, with ack timeout and inter-write gap.
module vga_mode_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  mode_req,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  cur_mode,
  output logic        cs,
  output logic        data_m_access,
  output logic        data_m_wr_en,
  output logic [18:0] data_m_addr,
  output logic [15:0] data_m_data_in,
  output logic [1:0]  data_m_bytesel,
  input  logic        data_m_ack
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REQ, S_WAIT, S_GAP, S_FINISH, S_ERR
  } state_t;

  // Number of table entries for a mode; 0 marks an unsupported mode.
  function automatic logic [1:0] tbl_len(input logic [7:0] m);
    case (m)
      8'h03, 8'h04, 8'h06: tbl_len = 2'd2;
      8'h13:               tbl_len = 2'd3;
      default:             tbl_len = 2'd0;
    endcase
  endfunction

  // Entry packed as {addr[18:0], data[15:0], bytesel[1:0]}.
  function automatic logic [36:0] tbl_entry(input logic [7:0] m, input logic [1:0] i);
    case ({m, i})
      {8'h03, 2'd0}: tbl_entry = {19'h1EC, 16'h0029, 2'b01};
      {8'h03, 2'd1}: tbl_entry = {19'h1EC, 16'h0000, 2'b10};
      {8'h04, 2'd0}: tbl_entry = {19'h1EC, 16'h000A, 2'b01};
      {8'h04, 2'd1}: tbl_entry = {19'h1EC, 16'h3000, 2'b10};
      {8'h06, 2'd0}: tbl_entry = {19'h1EC, 16'h001E, 2'b01};
      {8'h06, 2'd1}: tbl_entry = {19'h1EC, 16'h0F00, 2'b10};
      {8'h13, 2'd0}: tbl_entry = {19'h1E0, 16'h0010, 2'b01};
      {8'h13, 2'd1}: tbl_entry = {19'h1E0, 16'h0041, 2'b01};
      {8'h13, 2'd2}: tbl_entry = {19'h1EC, 16'h0008, 2'b01};
      default:       tbl_entry = '0;
    endcase
  endfunction

  state_t      state, state_n;
  logic [7:0]  mode_q, mode_n, cur_mode_n;
  logic [1:0]  idx, idx_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic        busy_n, done_n, error_n, access_n;
  logic [18:0] addr_n;
  logic [15:0] data_n;
  logic [1:0]  bsel_n;

  assign cs           = data_m_access;
  assign data_m_wr_en = data_m_access;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      mode_q         <= '0;
      idx            <= '0;
      tcnt           <= '0;
      gcnt           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cur_mode       <= 8'h03;
      data_m_access  <= 1'b0;
      data_m_addr    <= '0;
      data_m_data_in <= '0;
      data_m_bytesel <= '0;
    end else begin
      state          <= state_n;
      mode_q         <= mode_n;
      idx            <= idx_n;
      tcnt           <= tcnt_n;
      gcnt           <= gcnt_n;
      busy           <= busy_n;
      done           <= done_n;
      error          <= error_n;
      cur_mode       <= cur_mode_n;
      data_m_access  <= access_n;
      data_m_addr    <= addr_n;
      data_m_data_in <= data_n;
      data_m_bytesel <= bsel_n;
    end
  end

  always_comb begin
    state_n    = state;
    mode_n     = mode_q;
    idx_n      = idx;
    tcnt_n     = tcnt;
    gcnt_n     = gcnt;
    busy_n     = busy;
    done_n     = 1'b0;
    error_n    = error;
    cur_mode_n = cur_mode;
    access_n   = data_m_access;
    addr_n     = data_m_addr;
    data_n     = data_m_data_in;
    bsel_n     = data_m_bytesel;

    case (state)
      S_IDLE: begin
        if (start) begin
          mode_n  = mode_req;
          busy_n  = 1'b1;
          error_n = 1'b0;
          state_n = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (tbl_len(mode_q) == 2'd0) begin
          done_n  = 1'b1;
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = S_ERR;
        end else begin
          {addr_n, data_n, bsel_n} = tbl_entry(mode_q, 2'd0);
          access_n = 1'b1;
          idx_n    = '0;
          tcnt_n   = '0;
          state_n  = S_REQ;
        end
      end
      // Ack takes priority over the timeout on the last counted cycle.
      S_REQ, S_WAIT: begin
        if (data_m_ack) begin
          access_n = 1'b0;
          idx_n    = idx + 2'd1;
          gcnt_n   = '0;
          state_n  = S_GAP;
        end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
          access_n = 1'b0;
          done_n   = 1'b1;
          error_n  = 1'b1;
          busy_n   = 1'b0;
          state_n  = S_ERR;
        end else begin
          tcnt_n  = tcnt + 1'b1;
          state_n = S_WAIT;
        end
      end
      S_GAP: begin
        if (gcnt == GW'(GAP_CYCLES - 1)) begin
          if (idx == tbl_len(mode_q)) begin
            done_n     = 1'b1;
            busy_n     = 1'b0;
            error_n    = 1'b0;
            cur_mode_n = mode_q;
            state_n    = S_FINISH;
          end else begin
            {addr_n, data_n, bsel_n} = tbl_entry(mode_q, idx);
            access_n = 1'b1;
            tcnt_n   = '0;
            state_n  = S_REQ;
          end
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      S_FINISH, S_ERR: state_n = S_IDLE;
      default:         state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer: directed scenarios plus randomized
// mode/ack-delay runs checked against a table-driven transaction model.
module tb_vga_mode_sequencer;
  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mode_req = '0;
  logic        busy, done, error, cs, data_m_access, data_m_wr_en;
  logic [7:0]  cur_mode;
  logic [18:0] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [1:0]  data_m_bytesel;
  logic        data_m_ack = 1'b0;

  always #5 clk = ~clk;

  vga_mode_sequencer #(.ACK_TIMEOUT(TO), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode_req(mode_req),
    .busy(busy), .done(done), .error(error), .cur_mode(cur_mode), .cs(cs),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_addr(data_m_addr), .data_m_data_in(data_m_data_in),
    .data_m_bytesel(data_m_bytesel), .data_m_ack(data_m_ack)
  );

  typedef struct packed {
    logic [18:0] a;
    logic [15:0] d;
    logic [1:0]  b;
  } wr_t;

  wr_t         seen[$];
  wr_t         expw[$];
  int          dq[$];
  int unsigned compared = 0, mismatched = 0;
  int unsigned acc_cycles = 0, run_len = 0, max_run = 0, done_cycles = 0, low_run = 0;
  bit          unstable = 0, strobe_bad = 0, gap_bad = 0, had_acc = 0, idle_noise = 0;
  int          cur_delay = -1, wcnt = 0;
  wr_t         held, cur;
  logic [7:0]  model_mode = 8'h03;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave responder and bus monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    cur = {data_m_addr, data_m_data_in, data_m_bytesel};
    if (!reset_n) begin
      data_m_ack = 1'b0;
      run_len = 0;
    end else if (data_m_access) begin
      if (run_len == 0) begin
        held = cur;
        wcnt = 0;
        cur_delay = -1;
        if (dq.size() > 0) cur_delay = dq.pop_front();
        if (had_acc && low_run != 1) gap_bad = 1;
      end else if (cur !== held) begin
        unstable = 1;
      end
      run_len++;
      acc_cycles++;
      had_acc = 1;
      low_run = 0;
      data_m_ack = (cur_delay >= 0 && wcnt == cur_delay);
      wcnt++;
      if (data_m_ack) seen.push_back(cur);
    end else begin
      if (run_len > max_run) max_run = run_len;
      run_len = 0;
      low_run++;
      data_m_ack = idle_noise && ($urandom_range(0, 2) == 0);
    end
    if (data_m_wr_en !== data_m_access || cs !== data_m_access) strobe_bad = 1;
    if (done === 1'b1) done_cycles++;
  end

  task automatic build_expw(input logic [7:0] m);
    expw.delete();
    case (m)
      8'h03: begin expw.push_back({19'h1EC, 16'h0029, 2'b01}); expw.push_back({19'h1EC, 16'h0000, 2'b10}); end
      8'h04: begin expw.push_back({19'h1EC, 16'h000A, 2'b01}); expw.push_back({19'h1EC, 16'h3000, 2'b10}); end
      8'h06: begin expw.push_back({19'h1EC, 16'h001E, 2'b01}); expw.push_back({19'h1EC, 16'h0F00, 2'b10}); end
      8'h13: begin
        expw.push_back({19'h1E0, 16'h0010, 2'b01});
        expw.push_back({19'h1E0, 16'h0041, 2'b01});
        expw.push_back({19'h1EC, 16'h0008, 2'b01});
      end
      default: ;
    endcase
  endtask

  task automatic clear_mon();
    seen.delete();
    acc_cycles = 0; max_run = 0; done_cycles = 0; low_run = 0;
    unstable = 0; strobe_bad = 0; gap_bad = 0; had_acc = 0;
  endtask

  // One start request for mode m with ack delays already queued in dq.
  task automatic run(input logic [7:0] m, input bit poke, input bit noise);
    int  dl[$];
    int  n;
    bit  unsupported, timed_out, exp_err;
    dl = dq;
    build_expw(m);
    unsupported = (expw.size() == 0);
    timed_out = 0;
    for (int i = 0; i < expw.size(); i++) begin
      if (i >= dl.size() || dl[i] < 0 || dl[i] >= int'(TO)) begin
        while (expw.size() > i) void'(expw.pop_back());
        timed_out = 1;
        break;
      end
    end
    exp_err = unsupported || timed_out;
    clear_mon();
    idle_noise = noise;

    @(negedge clk); start = 1'b1; mode_req = m;
    @(negedge clk); start = 1'b0; mode_req = 8'($urandom);
    chk("busy_after_start", busy, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      if (done !== 1'b1) begin
        if (poke) start = 1'($urandom_range(0, 1));
        n++;
      end
    end
    start = 1'b0;
    chk("done_within_budget", (n < 2000), 1'b1);
    if (unsupported) chk("unsupported_latency", n, 0);
    chk("error_at_done", error, exp_err);
    chk("cur_mode_at_done", cur_mode, (exp_err ? model_mode : m));
    chk("busy_at_done", busy, 1'b0);
    if (!exp_err) model_mode = m;
    @(negedge clk);
    chk("done_dropped", done, 1'b0);
    chk("error_held", error, exp_err);
    @(negedge clk);
    idle_noise = 0;
    chk("done_pulse_width", done_cycles, 1);
    chk("write_count", seen.size(), expw.size());
    for (int i = 0; i < expw.size() && i < seen.size(); i++)
      chk("write_content", seen[i], expw[i]);
    chk("stable_during_wait", unstable, 1'b0);
    chk("strobes_track_access", strobe_bad, 1'b0);
    chk("gap_between_writes", gap_bad, 1'b0);
    if (timed_out) chk("timeout_access_cycles", max_run, TO);
    if (unsupported) chk("no_access_unsupported", acc_cycles, 0);
    dq.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_access", data_m_access, 1'b0);
    chk("rst_cs", cs, 1'b0);
    chk("rst_wr_en", data_m_wr_en, 1'b0);
    chk("rst_addr", data_m_addr, 19'h0);
    chk("rst_data", data_m_data_in, 16'h0);
    chk("rst_bytesel", data_m_bytesel, 2'b00);
    chk("rst_cur_mode", cur_mode, 8'h03);
  endtask

  initial begin
    logic [7:0] modes[4];
    logic [7:0] m;
    int         r;
    modes[0] = 8'h03; modes[1] = 8'h04; modes[2] = 8'h06; modes[3] = 8'h13;

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    dq = '{1, 1};           run(8'h04, 0, 0);
    run(8'h05, 0, 1);
    dq = '{-1};             run(8'h13, 0, 0);
    dq = '{1, 1};           run(8'h03, 0, 0);
    dq = '{2, 3};           run(8'h06, 1, 0);
    dq = '{0, 5, 5};        run(8'h13, 0, 1);
    dq = '{TO - 1, 0};      run(8'h04, 0, 0);
    dq = '{0, TO};          run(8'h06, 0, 0);
    dq = '{0, 0};           run(8'h06, 0, 0);

    // Reset in the middle of an outstanding access.
    clear_mon();
    dq = '{-1};
    @(negedge clk); start = 1'b1; mode_req = 8'h04;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("access_before_reset", data_m_access, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    model_mode = 8'h03;
    dq.delete();
    @(negedge clk);

    for (int it = 0; it < 12; it++) begin
      m = ($urandom_range(0, 4) == 4) ? 8'($urandom) : modes[$urandom_range(0, 3)];
      for (int k = 0; k < 3; k++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       dq.push_back($urandom_range(0, 6));
        else if (r == 7) dq.push_back(TO - 1);
        else if (r == 8) dq.push_back(TO);
        else             dq.push_back(-1);
      end
      run(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
